// File: rtl/zip_arbiter_pkg.sv
// ============================================================================
// zip_arbiter_pkg : shared FSM state type and widths for the zip arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package zip_arbiter_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] COUNT_ONE = 16'h1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/zip_arbiter_add.sv
// ============================================================================
// zip_arbiter_add : combinational 16-bit adder, wraps by default and
// saturates at all-ones when ZIP_ARBITER_SATURATE_EN is defined
// Revision 1.0
// ============================================================================
`default_nettype none

module zip_arbiter_add
  import zip_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

`ifdef ZIP_ARBITER_SATURATE_EN
  logic [DATA_W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sum  = full[DATA_W] ? {DATA_W{1'b1}} : full[DATA_W-1:0];
  end
`else
  always_comb begin
    sum = a + b;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/zip_arbiter.sv
// ============================================================================
// zip_arbiter : two-requester round-robin arbiter feeding a shared adder,
// IDLE -> FIRE -> EMIT handshake. Optional macro: ZIP_ARBITER_SATURATE_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module zip_arbiter
  import zip_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] R0_A_DATA,
  input  logic [DATA_W-1:0] R0_B_DATA,
  input  logic              R0_SEND,
  output logic              R0_ACK,
  input  logic [DATA_W-1:0] R1_A_DATA,
  input  logic [DATA_W-1:0] R1_B_DATA,
  input  logic              R1_SEND,
  output logic              R1_ACK,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic [DATA_W-1:0] Out1_COUNT,
  output logic              Out1_TAG,
  output logic              Out1_SEND,
  input  logic              Out1_RDY,
  output logic              BUSY
);

  state_t            state;
  logic              grant;
  logic              pri;
  logic              out_send;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_send;
  logic [DATA_W-1:0] sum;
  logic              fire_ok;

  always_comb begin
    sel_a    = grant ? R1_A_DATA : R0_A_DATA;
    sel_b    = grant ? R1_B_DATA : R0_B_DATA;
    sel_send = grant ? R1_SEND   : R0_SEND;
  end

  zip_arbiter_add u_add (
    .a   (sel_a),
    .b   (sel_b),
    .sum (sum)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      grant     <= 1'b0;
      pri       <= 1'b0;
      out_send  <= 1'b0;
      Out1_DATA <= '0;
      Out1_TAG  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (R0_SEND || R1_SEND) begin
            // a lone requester wins outright; a tie goes to the pointer
            grant <= (R0_SEND && R1_SEND) ? pri : R1_SEND;
            state <= FIRE;
          end
        end
        FIRE: begin
          if (sel_send) begin
            Out1_DATA <= sum;
            Out1_TAG  <= grant;
            pri       <= ~grant;
            out_send  <= 1'b1;
            state     <= EMIT;
          end else begin
            state <= IDLE;
          end
        end
        EMIT: begin
          if (Out1_RDY) begin
            out_send <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // handshake outputs are suppressed outright while reset is asserted
  assign fire_ok    = (state == FIRE) && sel_send && !RESET;
  assign R0_ACK     = fire_ok && !grant;
  assign R1_ACK     = fire_ok && grant;
  assign Out1_SEND  = out_send && !RESET;
  assign Out1_COUNT = Out1_SEND ? COUNT_ONE : '0;
  assign BUSY       = (state != IDLE);

endmodule

`default_nettype wire

// File: doc/zip_arbiter.md
ZIP_ARBITER -- requirements
Module: zip_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1 bit: sole clock, all state updates on rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: synchronous active-high reset.
REQ-003 SHALL have ports R0_A_DATA and R0_B_DATA, input, 16 bits each: requester 0 operands.
REQ-004 SHALL have port R0_SEND, input, 1 bit: requester 0 operands valid, held until R0_ACK.
REQ-005 SHALL have port R0_ACK, output, 1 bit: one-cycle pulse, requester 0 operands consumed.
REQ-006 SHALL have ports R1_A_DATA, R1_B_DATA, R1_SEND and R1_ACK, identical in width and meaning to REQ-003..REQ-005, for requester 1.
REQ-007 SHALL have port Out1_DATA, output, 16 bits: sum of the granted operands.
REQ-008 SHALL have port Out1_COUNT, output, 16 bits: 16'h1 while Out1_SEND=1, else 16'h0.
REQ-009 SHALL have port Out1_TAG, output, 1 bit: index of the requester that produced Out1_DATA.
REQ-010 SHALL have port Out1_SEND, output, 1 bit: result valid.
REQ-011 SHALL have port Out1_RDY, input, 1 bit: consumer ready; a transfer occurs in a cycle where Out1_SEND=1 and Out1_RDY=1.
REQ-012 SHALL have port BUSY, output, 1 bit: 1 when FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, FIRE and EMIT.
REQ-014 IDLE: if R0_SEND or R1_SEND, SHALL register the winner in GRANT and go to FIRE; otherwise SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: if one requester is active it wins; if both are active, the requester selected by pointer PRI wins.
REQ-016 FIRE: if the granted requester's SEND=1, SHALL pulse its ACK for exactly this cycle, load Out1_DATA = A+B of that requester, load Out1_TAG = GRANT, set PRI = ~GRANT and go to EMIT.
REQ-017 FIRE: if the granted requester's SEND=0 (protocol violation), SHALL assert no ACK, leave PRI unchanged and return to IDLE.
REQ-018 EMIT: SHALL hold Out1_SEND=1 with Out1_DATA and Out1_TAG stable; on Out1_RDY=1, SHALL complete the transfer and go to IDLE in the same cycle.
REQ-019 Latency SHALL be 2 cycles from SEND sampled in IDLE to Out1_SEND=1; minimum initiation interval SHALL be 3 cycles.
REQ-020 The non-granted requester SHALL never see ACK; a request held through another requester's transaction SHALL be granted next, since PRI now points to it.
REQ-021 Addition SHALL be 16-bit unsigned, wrapping modulo 2^16 unless REQ-026 applies.
REQ-022 At most one ACK SHALL be high in any cycle, and ACK SHALL only occur in FIRE.
REQ-023 Out1_SEND SHALL be high only in EMIT.

Reset
REQ-024 While RESET=1 (any state, including mid-FIRE or mid-EMIT), the following SHALL hold on the next edge: FSM=IDLE, PRI=0, GRANT=0, Out1_DATA=0, Out1_TAG=0, Out1_SEND=0, Out1_COUNT=0, R0_ACK=0, R1_ACK=0, BUSY=0; an in-flight result SHALL be discarded.
REQ-025 SHALL assert no ACK or Out1_SEND during a reset cycle.

Configuration
REQ-026 With ZIP_ARBITER_SATURATE_EN defined, a sum exceeding 16'hFFFF SHALL yield 16'hFFFF; without it, the sum SHALL wrap (low 16 bits).

Structure
REQ-027 Shared package zip_arbiter_pkg SHALL hold the FSM state enum (IDLE/FIRE/EMIT), DATA_W=16 and the COUNT_ONE=16'h1 constant.
REQ-028 Addition SHALL be in one sub-module, zip_arbiter_add (combinational; saturation per REQ-026); all other logic SHALL be in zip_arbiter.

Verification
REQ-029 Only R0_SEND, A=16'h0003, B=16'h0004, Out1_RDY=1 -> R0_ACK pulse at cycle 1; Out1_SEND, DATA=16'h0007, TAG=0, COUNT=16'h1 at cycle 2; IDLE at cycle 3.
REQ-030 Both SEND held continuously after reset, R0 0x0001+0x0001, R1 0x0010+0x0010 -> outputs alternate 0x0002(TAG0), 0x0020(TAG1), 0x0002(TAG0) ...
REQ-031 Out1_RDY=0 for 5 cycles in EMIT -> Out1_SEND and DATA stable, no ACK, BUSY=1; RDY=1 -> single transfer, then IDLE.
REQ-032 A=16'hFFFF, B=16'h0002 -> Out1_DATA=16'h0001 without macro; 16'hFFFF with ZIP_ARBITER_SATURATE_EN.
REQ-033 RESET asserted during EMIT -> next cycle Out1_SEND=0, DATA=0, IDLE, PRI=0; with both requesting afterwards, R0 is granted first.
REQ-034 R1 granted, R1_SEND dropped in FIRE -> no ACK, return to IDLE, PRI unchanged.
